// File: rtl/bp_me_pkg.sv
// Memory-endpoint message types and configuration shared by the CCE memory model.
// Holds the cce<->mem message layout, command/size enums and the model's state enum.
package bp_me_pkg;

   localparam int paddr_width_p         = 40;
   localparam int cce_block_width_p     = 512;
   localparam int lce_id_width_p        = 4;
   localparam int lce_assoc_p           = 8;
   localparam int block_bytes_lp        = cce_block_width_p / 8;
   localparam int block_offset_width_lp = $clog2(block_bytes_lp);
   localparam int way_id_width_lp       = $clog2(lce_assoc_p);
   localparam int uc_data_width_lp      = 64;

   typedef enum logic [3:0] {
      e_cce_mem_rd    = 4'b0000,
      e_cce_mem_wr    = 4'b0001,
      e_cce_mem_uc_rd = 4'b0010,
      e_cce_mem_uc_wr = 4'b0011,
      e_cce_mem_pre   = 4'b0100,
      e_cce_mem_wb    = 4'b0101
   } bp_cce_mem_cmd_type_e;

   typedef enum logic [2:0] {
      e_mem_size_1  = 3'b000,
      e_mem_size_2  = 3'b001,
      e_mem_size_4  = 3'b010,
      e_mem_size_8  = 3'b011,
      e_mem_size_16 = 3'b100,
      e_mem_size_32 = 3'b101,
      e_mem_size_64 = 3'b110
   } bp_mem_msg_size_e;

   typedef struct packed {
      logic [lce_id_width_p-1:0]  lce_id;
      logic [way_id_width_lp-1:0] way_id;
   } bp_cce_mem_payload_s;

   typedef struct packed {
      bp_cce_mem_cmd_type_e          msg_type;
      logic [paddr_width_p-1:0]      addr;
      bp_mem_msg_size_e              size;
      bp_cce_mem_payload_s           payload;
      logic [cce_block_width_p-1:0]  data;
   } bp_cce_mem_msg_s;

   localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

   typedef enum logic [1:0] {
      eInit  = 2'd0,
      eReady = 2'd1,
      eWait  = 2'd2,
      eSend  = 2'd3
   } bp_mem_model_state_e;

   // Uncached accesses are at most one 64-bit word; larger size codes collapse to 8 bytes.
   function automatic logic [3:0] uc_size_bytes(input bp_mem_msg_size_e size);
      case (size)
         e_mem_size_1: uc_size_bytes = 4'd1;
         e_mem_size_2: uc_size_bytes = 4'd2;
         e_mem_size_4: uc_size_bytes = 4'd4;
         default:      uc_size_bytes = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/bp_cce_mem_line_rmw.sv
// Byte-granular read/merge of one cache line for uncached accesses.
// The offset is truncated down to the access size before extracting or merging.
module bp_cce_mem_line_rmw
   import bp_me_pkg::*;
(
   input  logic [cce_block_width_p-1:0]     line_i,
   input  logic [block_offset_width_lp-1:0] offset_i,
   input  logic [2:0]                       size_i,
   input  logic [uc_data_width_lp-1:0]      wdata_i,
   output logic [cce_block_width_p-1:0]     line_o,
   output logic [uc_data_width_lp-1:0]      rdata_o
);

   localparam int pad_lp = cce_block_width_p - uc_data_width_lp;

   logic [3:0]                       size_bytes;
   logic [block_offset_width_lp-1:0] aligned_offset;
   logic [block_offset_width_lp+2:0] shamt;
   logic [uc_data_width_lp-1:0]      word_mask;
   logic [cce_block_width_p-1:0]     line_mask;
   logic [cce_block_width_p-1:0]     line_wdata;

   always_comb begin
      size_bytes     = uc_size_bytes(bp_mem_msg_size_e'(size_i));
      aligned_offset = offset_i & ~(block_offset_width_lp'(size_bytes) - block_offset_width_lp'(1));
      shamt          = {aligned_offset, 3'b000};
      word_mask      = (size_bytes == 4'd8) ? '1
                     : ((uc_data_width_lp'(1) << {size_bytes, 3'b000}) - uc_data_width_lp'(1));
      line_mask      = {{pad_lp{1'b0}}, word_mask} << shamt;
      line_wdata     = {{pad_lp{1'b0}}, wdata_i & word_mask} << shamt;
      line_o         = (line_i & ~line_mask) | line_wdata;
      rdata_o        = uc_data_width_lp'(line_i >> shamt) & word_mask;
   end

endmodule

// File: rtl/bp_cce_mem_latency_model.sv
// Fixed-latency memory endpoint for the CCE: one outstanding command, flop-array
// backing store that is zeroed line-by-line after every reset.
module bp_cce_mem_latency_model
   import bp_me_pkg::*;
#(
   parameter int mem_els_p = 64,
   parameter int latency_p = 4
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
   input  logic                            mem_cmd_v_i,
   output logic                            mem_cmd_ready_o,
   output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
   output logic                            mem_resp_v_o,
   input  logic                            mem_resp_yumi_i
);

   localparam int idx_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
   localparam int cnt_width_lp = $clog2(latency_p + 1);

   if (latency_p < 1) begin : g_bad_latency
      $error("bp_cce_mem_latency_model: latency_p must be >= 1");
   end

   bp_mem_model_state_e state_q, state_d;
   logic [idx_width_lp-1:0] idx_q, idx_d;
   logic [cnt_width_lp-1:0] cnt_q, cnt_d;
   bp_cce_mem_msg_s resp_q, resp_d;
   bp_cce_mem_msg_s cmd_s;

   logic [cce_block_width_p-1:0] mem_q [mem_els_p];

   logic                         wr_en;
   logic [idx_width_lp-1:0]      wr_idx;
   logic [cce_block_width_p-1:0] wr_line;

   logic [idx_width_lp-1:0]      cmd_line_idx;
   logic [cce_block_width_p-1:0] cmd_line;
   logic [cce_block_width_p-1:0] rmw_line;
   logic [uc_data_width_lp-1:0]  rmw_rdata;

   assign cmd_s        = mem_cmd_i;
   // Upper address bits are ignored, so addresses alias every mem_els_p lines.
   assign cmd_line_idx = cmd_s.addr[block_offset_width_lp +: idx_width_lp];
   assign cmd_line     = mem_q[cmd_line_idx];

   bp_cce_mem_line_rmw u_rmw (
      .line_i   (cmd_line),
      .offset_i (cmd_s.addr[block_offset_width_lp-1:0]),
      .size_i   (cmd_s.size),
      .wdata_i  (cmd_s.data[uc_data_width_lp-1:0]),
      .line_o   (rmw_line),
      .rdata_o  (rmw_rdata)
   );

   // Handshakes: a command transfers on a cycle with mem_cmd_v_i & mem_cmd_ready_o;
   // the response is offered with mem_resp_v_o and consumed on mem_resp_yumi_i.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      cnt_d           = cnt_q;
      resp_d          = resp_q;
      wr_en           = 1'b0;
      wr_idx          = idx_q;
      wr_line         = '0;
      mem_cmd_ready_o = 1'b0;
      mem_resp_v_o    = 1'b0;
      mem_resp_o      = '0;

      case (state_q)
         eInit: begin
            wr_en   = 1'b1;
            wr_idx  = idx_q;
            wr_line = '0;
            idx_d   = idx_q + idx_width_lp'(1);
            if (idx_q == idx_width_lp'(mem_els_p - 1)) begin
               state_d = eReady;
            end
         end

         eReady: begin
            mem_cmd_ready_o = 1'b1;
            if (mem_cmd_v_i) begin
               resp_d      = cmd_s;
               resp_d.data = '0;
               wr_idx      = cmd_line_idx;
               // Storage is written in the accept cycle so later reads see it.
               case (cmd_s.msg_type)
                  e_cce_mem_rd:    resp_d.data = cmd_line;
                  e_cce_mem_wr: begin
                     wr_en   = 1'b1;
                     wr_line = cmd_s.data;
                  end
                  e_cce_mem_uc_rd: resp_d.data = cce_block_width_p'(rmw_rdata);
                  e_cce_mem_uc_wr: begin
                     wr_en   = 1'b1;
                     wr_line = rmw_line;
                  end
                  default: ;
               endcase
               cnt_d   = cnt_width_lp'(latency_p - 1);
               state_d = (latency_p == 1) ? eSend : eWait;
            end
         end

         eWait: begin
            cnt_d = cnt_q - cnt_width_lp'(1);
            if (cnt_d == '0) begin
               state_d = eSend;
            end
         end

         eSend: begin
            mem_resp_v_o = 1'b1;
            mem_resp_o   = resp_q;
            if (mem_resp_yumi_i) begin
               state_d = eReady;
            end
         end

         default: state_d = eInit;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= eInit;
         idx_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_n_i && wr_en) begin
         mem_q[wr_idx] <= wr_line;
      end
   end

   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      mem_resp_yumi_i |-> mem_resp_v_o);

endmodule

// File: tb/tb_bp_cce_mem_latency_model.sv
// Directed bench for bp_cce_mem_latency_model: init length, latency, full-line and
// uncached read/write, backpressure, aliasing and reset during a pending command.
module tb_bp_cce_mem_latency_model;
   import bp_me_pkg::*;

   localparam int MEM_ELS = 64;
   localparam int LAT     = 4;
   localparam int W       = cce_mem_msg_width_lp;
   localparam int BW      = cce_block_width_p;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [W-1:0]  mem_cmd;
   logic          cmd_v;
   logic          cmd_ready;
   logic [W-1:0]  mem_resp;
   logic          resp_v;
   logic          yumi;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bp_cce_mem_latency_model #(
      .mem_els_p (MEM_ELS),
      .latency_p (LAT)
   ) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .mem_cmd_i       (mem_cmd),
      .mem_cmd_v_i     (cmd_v),
      .mem_cmd_ready_o (cmd_ready),
      .mem_resp_o      (mem_resp),
      .mem_resp_v_o    (resp_v),
      .mem_resp_yumi_i (yumi)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                          input bp_mem_msg_size_e s, input logic [6:0] p,
                                          input logic [BW-1:0] d);
      bp_cce_mem_msg_s m;
      m.msg_type = t;
      m.addr     = a;
      m.size     = s;
      m.payload  = bp_cce_mem_payload_s'(p);
      m.data     = d;
      return m;
   endfunction

   // Apply reset for two edges, check idle outputs, release and time the init sweep.
   task automatic do_reset(input string tag);
      int cnt;
      reset_n = 1'b0;
      cmd_v   = 1'b0;
      yumi    = 1'b0;
      mem_cmd = '0;
      @(posedge clk); #1;
      chk({tag, " rst_ready"}, W'(cmd_ready), W'(0));
      chk({tag, " rst_resp_v"}, W'(resp_v), W'(0));
      chk({tag, " rst_resp"}, mem_resp, '0);
      @(posedge clk); #1;
      chk({tag, " rst_resp_v2"}, W'(resp_v), W'(0));
      reset_n = 1'b1;
      cnt = 0;
      while (!cmd_ready && cnt < 300) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, " init_cycles"}, W'(cnt), W'(MEM_ELS));
   endtask

   // Issue one command, check latency, response contents, optional held backpressure,
   // then consume it and check ready returns the next cycle.
   task automatic txn(input string tag, input bp_cce_mem_msg_s cmd,
                      input logic [BW-1:0] exp_data, input int hold);
      bp_cce_mem_msg_s exp;
      int guard;
      int lat;
      exp      = cmd;
      exp.data = exp_data;
      guard    = 0;
      while (!cmd_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      mem_cmd = cmd;
      cmd_v   = 1'b1;
      @(posedge clk); #1;
      cmd_v   = 1'b0;
      mem_cmd = '0;
      lat = 1;
      while (!resp_v && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, W'(lat), W'(LAT));
      chk({tag, " resp"}, mem_resp, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold_flags"}, W'({resp_v, cmd_ready}), W'(2'b10));
         chk({tag, " hold_resp"}, mem_resp, exp);
      end
      if (resp_v) begin
         yumi = 1'b1;
         @(posedge clk); #1;
         yumi = 1'b0;
      end
      chk({tag, " ready_after"}, W'({resp_v, cmd_ready}), W'(2'b01));
   endtask

   initial begin
      logic [BW-1:0] a5;
      logic [BW-1:0] pat;
      logic [BW-1:0] zero;
      logic [BW-1:0] beef_line;

      a5        = {16{32'hA5A5A5A5}};
      pat       = {8{64'h0123456789ABCDEF}};
      zero      = '0;
      beef_line = BW'(64'hDEADBEEF) << 32;

      reset_n = 1'b0;
      cmd_v   = 1'b0;
      yumi    = 1'b0;
      mem_cmd = '0;

      do_reset("por");
      txn("rd0", mk(e_cce_mem_rd, 40'h0, e_mem_size_64, 7'h01, zero), zero, 0);

      txn("wr80", mk(e_cce_mem_wr, 40'h80, e_mem_size_64, 7'h15, a5), zero, 0);
      txn("rd80", mk(e_cce_mem_rd, 40'h80, e_mem_size_64, 7'h2A, zero), a5, 0);
      txn("rd80_lowbits", mk(e_cce_mem_rd, 40'h93, e_mem_size_64, 7'h33, pat), a5, 0);

      txn("ucwr1004", mk(e_cce_mem_uc_wr, 40'h1004, e_mem_size_4, 7'h05, BW'(64'hDEADBEEF)), zero, 0);
      txn("rd1000", mk(e_cce_mem_rd, 40'h1000, e_mem_size_64, 7'h06, zero), beef_line, 0);
      txn("ucrd1004_2", mk(e_cce_mem_uc_rd, 40'h1004, e_mem_size_2, 7'h07, zero), BW'(16'hBEEF), 0);
      txn("ucrd1005_2", mk(e_cce_mem_uc_rd, 40'h1005, e_mem_size_2, 7'h08, zero), BW'(16'hBEEF), 0);
      txn("ucrd1006_1", mk(e_cce_mem_uc_rd, 40'h1006, e_mem_size_1, 7'h09, zero), BW'(8'hAD), 0);
      txn("ucrd1000_8", mk(e_cce_mem_uc_rd, 40'h1000, e_mem_size_8, 7'h0A, zero),
          BW'(64'hDEADBEEF_00000000), 0);
      txn("pre", mk(e_cce_mem_pre, 40'h1000, e_mem_size_64, 7'h0B, pat), zero, 0);
      txn("rd1000_after_pre", mk(e_cce_mem_rd, 40'h1000, e_mem_size_64, 7'h0C, zero), beef_line, 0);

      txn("bp_rd80", mk(e_cce_mem_rd, 40'h80, e_mem_size_64, 7'h7F, zero), a5, 20);

      txn("wr0", mk(e_cce_mem_wr, 40'h0, e_mem_size_64, 7'h11, pat), zero, 0);
      txn("alias_rd", mk(e_cce_mem_rd, 40'(MEM_ELS * block_bytes_lp), e_mem_size_64, 7'h12, zero), pat, 0);

      while (!cmd_ready) begin
         @(posedge clk); #1;
      end
      mem_cmd = mk(e_cce_mem_rd, 40'h80, e_mem_size_64, 7'h13, zero);
      cmd_v   = 1'b1;
      @(posedge clk); #1;
      cmd_v   = 1'b0;
      @(posedge clk); #1;
      do_reset("mid");
      for (int i = 0; i < LAT; i++) begin
         chk("mid no_resp", W'(resp_v), W'(0));
         @(posedge clk); #1;
      end
      txn("rd80_post_reset", mk(e_cce_mem_rd, 40'h80, e_mem_size_64, 7'h14, zero), zero, 0);
      txn("rd0_post_reset", mk(e_cce_mem_rd, 40'h0, e_mem_size_64, 7'h16, zero), zero, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
